// File: rtl/xdata_responder.sv
// MOVX external-data slave: latches a request, waits WAIT_CYCLES, then pulses ack with read/write result.
// Latency WAIT_CYCLES+1 cycles from the sampling edge; requests are ignored while busy, no queuing.
module xdata_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        busy
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } xreq_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  xreq_t      cur;
  xreq_t      inc;
  xreq_t      tgt;
  logic       held;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       accept;
  logic       enter_resp;
  logic       in_range;
  logic       commit;

  logic [7:0] mem [DEPTH];

  assign inc = '{we: we, addr: addr, wdata: wdata};

  // A req held continuously since its own acceptance restarts straight out of RESP;
  // a req that rises while busy is simply dropped.
  assign accept     = req && ((state == IDLE) || (state == RESP && held));
  assign enter_resp = (WAIT_CYCLES == 0) ? accept : (state == WAIT && cnt == 4'd1);

  // With no wait states the transaction resolves on the very edge that samples it.
  assign tgt        = (WAIT_CYCLES == 0) ? inc : cur;
  assign in_range   = ({16'h0000, tgt.addr} < DEPTH_W);
  assign commit     = rst && enter_resp && tgt.we && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur     <= '0;
      held    <= 1'b0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur  <= inc;
        cnt  <= WAIT_INIT;
        held <= 1'b1;
      end else begin
        held <= held & req;
        if (state == WAIT) begin
          cnt <= cnt - 4'd1;
        end
      end
      if (enter_resp) begin
        err_q <= !in_range;
        if (!in_range) begin
          rdata_q <= 8'hFF;
        end else if (tgt.we) begin
          rdata_q <= tgt.wdata;
        end else begin
          rdata_q <= mem[tgt.addr[AW-1:0]];
        end
      end
    end
  end

  // Storage has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[tgt.addr[AW-1:0]] <= tgt.wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (enter_resp) state_nxt = RESP;
      RESP:    state_nxt = accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack   = 1'b0;
    err   = 1'b0;
    rdata = 8'h00;
    busy  = (state != IDLE);
    if (state == RESP) begin
      ack   = 1'b1;
      err   = err_q;
      rdata = rdata_q;
    end
  end

endmodule
